// File: rtl/cgra_input_mem_node.sv
// Stream-read node: issues strided word reads under credit control, buffers the in-order
// responses in a small FIFO and streams them out on a valid/ready port.
module cgra_input_mem_node #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_v,
  input  logic                  dout_r,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [SIZE_WIDTH-1:0] issued_q, issued_d;
  logic [SIZE_WIDTH-1:0] delivered_q, delivered_d;
  logic [CntW-1:0]       outst_q, outst_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

  logic            gnt_fire, push, pop, credit_ok;
  logic [CntW:0]   credit_used;

  // Credits come from registered occupancy only, so dout_r never reaches mem_req.
  always_comb begin
    credit_used = {1'b0, outst_q} + {1'b0, count_q};
    credit_ok   = credit_used < (CntW + 1)'(FIFO_DEPTH);
    mem_req     = (state_q == StIssue) && (issued_q < size_q) && credit_ok;
    gnt_fire    = mem_req && mem_gnt;
    push        = mem_rvalid && (outst_q != '0);
    dout_v      = (count_q != '0);
    pop         = dout_v && dout_r;
    dout        = dout_v ? mem_q[rptr_q] : '0;
    mem_addr    = addr_q;
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    size_d      = size_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    outst_d     = outst_q;
    count_d     = count_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    mem_d       = mem_q;

    if (gnt_fire) begin
      issued_d = issued_q + SIZE_WIDTH'(1);
      addr_d   = addr_q + stride_q;
    end

    unique case ({gnt_fire, push})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase

    if (push) begin
      mem_d[wptr_q] = mem_rdata;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d      = rptr_q + PtrW'(1);
      delivered_d = delivered_q + SIZE_WIDTH'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = base_addr;
          stride_d    = stride;
          size_d      = size;
          issued_d    = '0;
          delivered_d = '0;
          outst_d     = '0;
          state_d     = (size == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (gnt_fire && (issued_d == size_q)) state_d = StDrain;
      end
      StDrain: begin
        // Leave on the last pop itself so done follows it by exactly one cycle.
        if (delivered_d == size_q) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      stride_q    <= '0;
      size_q      <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      outst_q     <= '0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      size_q      <= size_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      outst_q     <= outst_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_cgra_input_mem_node.sv
// Bench for cgra_input_mem_node: a memory model with random grant/latency feeds the DUT;
// expected addresses and words are queued at start and checked by a negedge monitor.
module tb_cgra_input_mem_node;

  localparam int unsigned Depth = 4;

  logic        clk, rst, start;
  logic [31:0] base_addr, stride;
  logic [15:0] size;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata, dout;
  logic        dout_v, dout_r, busy, done;

  cgra_input_mem_node #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .SIZE_WIDTH(16),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride), .size(size),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .dout(dout), .dout_v(dout_v), .dout_r(dout_r), .busy(busy),
    .done(done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Environment knobs set by the stimulus process.
  int gnt_mode = 0;  // 0: always grant, 1: 50% random
  int lat_min  = 1;
  int lat_max  = 1;
  int rdy_mode = 0;  // 0: ready, 1: stalled, 2: random

  // Memory model and scoreboard state.
  logic [31:0] resp_data[$];
  int          resp_due[$];
  int          last_due = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          model_busy = 0;
  int          done_due   = -10;
  int          done_cyc   = -1;
  int          done_count = 0;
  int          gnt_count  = 0;
  int          inflight   = 0;
  bit          hold_prev  = 0;
  logic [31:0] hold_data  = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Input driver: grant, responses and downstream ready, changed just after each edge.
  initial begin
    mem_gnt    = 0;
    mem_rvalid = 0;
    mem_rdata  = '0;
    dout_r     = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mem_gnt = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
        mem_rvalid = 1;
        mem_rdata  = resp_data.pop_front();
        void'(resp_due.pop_front());
      end else begin
        mem_rvalid = 0;
        mem_rdata  = $urandom;
      end
      case (rdy_mode)
        0:       dout_r = 1;
        1:       dout_r = 0;
        default: dout_r = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: samples mid-cycle, schedules memory responses and scores DUT outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && mem_gnt) begin
        int due;
        due = cyc + int'($urandom_range(lat_min, lat_max));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        resp_data.push_back(mem_word(mem_addr));
        resp_due.push_back(due);
      end
      if (rst) begin
        exp_addr.delete();
        exp_data.delete();
        model_busy = 0;
        done_due   = -10;
        inflight   = 0;
        hold_prev  = 0;
      end else begin
        check("busy", busy, model_busy);
        if (mem_req && mem_gnt) begin
          gnt_count++;
          inflight++;
          check("credit", inflight <= int'(Depth), 1);
          if (exp_addr.size() == 0) check("unexpected_req", 1, 0);
          else check("mem_addr", mem_addr, exp_addr.pop_front());
        end else if (exp_addr.size() == 0) begin
          check("req_idle", mem_req, 0);
        end
        if (hold_prev) begin
          check("hold_valid", dout_v, 1);
          check("hold_data", dout, hold_data);
        end
        hold_prev = dout_v && !dout_r;
        hold_data = dout;
        if (dout_v && dout_r) begin
          inflight--;
          if (exp_data.size() == 0) check("unexpected_dout", 1, 0);
          else begin
            check("dout", dout, exp_data.pop_front());
            if (exp_data.size() == 0 && exp_addr.size() == 0 && model_busy) done_due = cyc + 1;
          end
        end else if (exp_data.size() == 0) begin
          check("dout_v_idle", dout_v, 0);
        end
        check("done", done, cyc == done_due);
        if (done) begin
          done_count++;
          done_cyc = cyc;
        end
        if (start && !model_busy) begin
          for (int i = 0; i < int'(size); i++) begin
            logic [31:0] a;
            a = base_addr + stride * 32'(i);
            exp_addr.push_back(a);
            exp_data.push_back(mem_word(a));
          end
          model_busy = 1;
          inflight   = 0;
          if (size == '0) done_due = cyc + 1;
        end else if (cyc == done_due) begin
          model_busy = 0;
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] b, input logic [31:0] s, input logic [15:0] n,
                          output int t);
    @(posedge clk);
    #1;
    base_addr = b;
    stride    = s;
    size      = n;
    start     = 1;
    t         = cyc;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic wait_done(input int bound);
    int d0;
    int n;
    d0 = done_count;
    n  = 0;
    while (done_count == d0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_count == d0) check("done_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_dout_v"}, dout_v, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int t, t2, g0;
    rst       = 1;
    start     = 0;
    base_addr = '0;
    stride    = '0;
    size      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check_zero("reset");

    // Basic stream at full rate: done 8 cycles after start.
    do_start(32'h100, 32'd4, 16'd5, t);
    wait_done(100);
    check("t1_done_latency", done_cyc - t, 8);

    // Downstream stalled: credits must cap issue at the FIFO depth.
    rdy_mode = 1;
    g0 = gnt_count;
    do_start(32'h100, 32'd4, 16'd5, t);
    repeat (9) @(posedge clk);
    @(negedge clk);
    #1;
    check("stall_grants", gnt_count - g0, Depth);
    check("stall_mem_req", mem_req, 0);
    rdy_mode = 0;
    wait_done(100);

    // Negative stride wraps through zero.
    do_start(32'h4, 32'hFFFF_FFFC, 16'd3, t);
    wait_done(100);

    // Empty stream.
    do_start(32'h500, 32'd4, 16'd0, t);
    wait_done(10);
    check("size0_done_latency", done_cyc - t, 1);

    // Random grant, latency and ready; a second start while busy must be ignored.
    gnt_mode = 1;
    lat_min  = 1;
    lat_max  = 3;
    rdy_mode = 2;
    for (int s = 0; s < 6; s++) begin
      do_start($urandom & 32'hFFFF_FFFC, $urandom, 16'($urandom_range(1, 20)), t);
      if (s == 0) do_start(32'hDEAD_0000, 32'd8, 16'd7, t2);
      wait_done(2000);
    end

    // Reset mid-stream with requests in flight; their late responses must be dropped.
    gnt_mode = 0;
    lat_min  = 3;
    lat_max  = 3;
    rdy_mode = 0;
    do_start(32'h2000, 32'd8, 16'd6, t);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    check_zero("midrst");
    repeat (8) @(posedge clk);
    lat_min = 1;
    lat_max = 2;
    do_start(32'h3000, 32'd4, 16'd2, t);
    wait_done(100);

    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    check("leftover_data", exp_data.size(), 0);
    check("leftover_addr", exp_addr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
